masked_share_decoder: RTL and testbench

- Receiving end of the 2-share Boolean masking interface. Serially accepts share pairs (y0, y1), one bit position per beat, LSB first, and assembles two WIDTH-bit share words.
- Recombines the shares (unmasks) only after both share words are fully registered. Presents the plaintext word on a valid/ready output.
- Zeroizes share and plaintext registers after use.
- Sits at the boundary between the masked datapath and unmasked consumers: result readout and the test harness.

---
 rtl/masking_pkg.sv | 16 +
 rtl/share_collector.sv | 61 ++++++
 rtl/masked_share_decoder.sv | 97 +++++++++
 tb/tb_masked_share_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/masking_pkg.sv
// Shared definitions for the 2-share Boolean masking interface.
// Used by the share decoder and its share collector.
package masking_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMBINE = 2'd1,
    HOLD    = 2'd2
  } dec_state_t;

  localparam int NUM_SHARES = 2;

  // 1: the first beat of a word carries bit 0.
  localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/share_collector.sv
// Assembles two share words one bit position per beat.
// Flags the beat that completes a word.
module share_collector
  import masking_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             beat_i,
  input  logic             y0_i,
  input  logic             y1_i,
  output logic [WIDTH-1:0] sh0_o,
  output logic [WIDTH-1:0] sh1_o,
  output logic [CW-1:0]    cnt_o,
  output logic             last_o
);

  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    bit_idx;

  assign bit_idx = LSB_FIRST ? cnt_q : CW'(WIDTH - 1) - cnt_q;
  assign last_o  = beat_i && (cnt_q == CW'(WIDTH - 1));

  // The explicit last-beat compare wraps the counter, so non-power-of-2 widths never overrun.
  always_comb begin
    sh0_d = sh0_q;
    sh1_d = sh1_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sh0_d = '0;
      sh1_d = '0;
      cnt_d = '0;
    end else if (beat_i) begin
      sh0_d[bit_idx] = y0_i;
      sh1_d[bit_idx] = y1_i;
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh0_q <= '0;
      sh1_q <= '0;
      cnt_q <= '0;
    end else begin
      sh0_q <= sh0_d;
      sh1_q <= sh1_d;
      cnt_q <= cnt_d;
    end
  end

  assign sh0_o = sh0_q;
  assign sh1_o = sh1_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/masked_share_decoder.sv
// Receives serial 2-share bit pairs and unmasks the registered share words.
// Shares are wiped when the plaintext is produced, and the plaintext is wiped on handoff.
module masked_share_decoder
  import masking_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_y0,
  input  logic             in_y1,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  dec_state_t       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] sh0, sh1;
  logic [CW-1:0]    cnt;
  logic             last_beat;
  logic             beat;
  logic             clear;

  assign in_ready = (state_q == COLLECT);
  assign beat     = in_valid && in_ready && !abort;

  share_collector #(.WIDTH(WIDTH)) u_coll (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .beat_i  (beat),
    .y0_i    (in_y0),
    .y1_i    (in_y1),
    .sh0_o   (sh0),
    .sh1_o   (sh1),
    .cnt_o   (cnt),
    .last_o  (last_beat)
  );

  // Unmasking reads only registered shares and wipes them in the same cycle.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    clear       = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (last_beat) state_d = COMBINE;
      end
      COMBINE: begin
        out_data_d  = sh0 ^ sh1;
        out_valid_d = 1'b1;
        clear       = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_data_d  = '0;
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (abort) begin
      state_d     = COLLECT;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      clear       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (cnt != '0) || (state_q != COLLECT);

endmodule

// File: tb/tb_masked_share_decoder.sv
// Self-checking bench for masked_share_decoder at WIDTH=8 and WIDTH=5.
// Expected plaintexts go into scoreboards when words are sent and are checked on each handshake.
module tb_masked_share_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic       rst = 1'b1, in_valid = 1'b0, in_y0 = 1'b0, in_y1 = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;

  masked_share_decoder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_y0(in_y0), .in_y1(in_y1), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // WIDTH=5 instance
  logic       in_valid5 = 1'b0, y0_5 = 1'b0, y1_5 = 1'b0, abort5 = 1'b0, out_ready5 = 1'b0;
  logic       in_ready5, out_valid5, busy5;
  logic [4:0] out_data5;

  masked_share_decoder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_y0(y0_5), .in_y1(y1_5), .abort(abort5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_data(out_data5), .busy(busy5)
  );

  logic [7:0] exp8_q[$];
  logic [4:0] exp5_q[$];
  int hs8 = 0;
  int hs5 = 0;
  int hs5_cyc[$];
  bit count_low5 = 1'b0;
  int low5 = 0;

  // Handshake scoreboards, sampled on the falling edge before the accepting rising edge.
  always @(negedge clk) begin
    if (!rst && !abort && out_valid && out_ready) begin
      logic [7:0] e;
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL hs8_unexpected got=%h expected=none", out_data);
      end else begin
        e = exp8_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("[TB] FAIL hs8_data got=%h expected=%h", out_data, e);
        end
      end
      hs8++;
    end
    if (!rst && !abort5 && out_valid5 && out_ready5) begin
      logic [4:0] e5;
      checks++;
      if (exp5_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL hs5_unexpected got=%h expected=none", out_data5);
      end else begin
        e5 = exp5_q.pop_front();
        if (out_data5 !== e5) begin
          errors++;
          $display("[TB] FAIL hs5_data got=%h expected=%h", out_data5, e5);
        end
      end
      hs5++;
      hs5_cyc.push_back(cyc);
    end
    if (count_low5 && !in_ready5) low5++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // One bit pair per accepted beat; a set gap bit inserts an idle cycle before that beat.
  task automatic send_word(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps[i]) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_y0 = s0[i];
      in_y1 = s1[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_busy5", 32'(busy5), 32'd0);
  endtask

  task automatic test_basic();
    int hs0;
    hs0 = hs8;
    out_ready = 1'b1;
    exp8_q.push_back(8'hA5);
    send_word(8'h3C, 8'h99, 8'h00);
    chk("basic_combine_valid", 32'(out_valid), 32'd0);
    chk("basic_combine_busy", 32'(busy), 32'd1);
    tick();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'hA5);
    chk("basic_sh0_zero", 32'(dut.u_coll.sh0_q), 32'd0);
    chk("basic_sh1_zero", 32'(dut.u_coll.sh1_q), 32'd0);
    tick();
    chk("basic_after_valid", 32'(out_valid), 32'd0);
    chk("basic_after_data", 32'(out_data), 32'd0);
    chk("basic_after_ready", 32'(in_ready), 32'd1);
    chk("basic_hs_count", 32'(hs8 - hs0), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs8;
    out_ready = 1'b0;
    exp8_q.push_back(8'hFF);
    send_word(8'h0F, 8'hF0, 8'b0100_1000);
    tick();
    in_valid = 1'b1;
    in_y0 = 1'b1;
    in_y1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'hFF);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_released_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_count", 32'(hs8 - hs0), 32'd1);
    chk("bp_no_stray_beat", 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_y0 = 1'b1;
      in_y1 = 1'b0;
      tick();
    end
    chk("abort_partial_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sh0_zero", 32'(dut.u_coll.sh0_q), 32'd0);
    out_ready = 1'b1;
    exp8_q.push_back(8'h5A);
    send_word(8'h00, 8'h5A, 8'h00);
    tick();
    chk("abort_word_data", 32'(out_data), 32'h5A);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_hold();
    int hs0;
    logic [7:0] dropped;
    out_ready = 1'b0;
    exp8_q.push_back(8'hC3);
    send_word(8'hC3 ^ 8'h6E, 8'h6E, 8'h00);
    tick();
    chk("rh_hold_data", 32'(out_data), 32'hC3);
    hs0 = hs8;
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("rh_valid", 32'(out_valid), 32'd0);
    chk("rh_data", 32'(out_data), 32'd0);
    chk("rh_in_ready", 32'(in_ready), 32'd1);
    chk("rh_no_hs", 32'(hs8 - hs0), 32'd0);
    if (exp8_q.size() != 0) dropped = exp8_q.pop_front();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] words [2];
    logic [4:0] m;
    logic [4:0] s0;
    int guard;
    words[0] = 5'h15;
    words[1] = 5'h0A;
    m = 5'h0B;
    low5 = 0;
    count_low5 = 1'b1;
    out_ready5 = 1'b1;
    in_valid5 = 1'b1;
    for (int w = 0; w < 2; w++) begin
      exp5_q.push_back(words[w]);
      s0 = words[w] ^ m;
      for (int i = 0; i < 5; i++) begin
        guard = 0;
        while (!in_ready5 && guard < 10) begin
          tick();
          guard++;
        end
        if (guard >= 10) begin
          errors++;
          $display("[TB] FAIL b2b_ready_timeout got=0 expected=1");
        end
        y0_5 = s0[i];
        y1_5 = m[i];
        tick();
      end
    end
    in_valid5 = 1'b0;
    guard = 0;
    while (hs5 < 2 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    tick();
    count_low5 = 1'b0;
    chk("b2b_hs_count", 32'(hs5), 32'd2);
    if (hs5_cyc.size() == 2) chk("b2b_spacing", 32'(hs5_cyc[1] - hs5_cyc[0]), 32'd7);
    else chk("b2b_spacing_samples", 32'(hs5_cyc.size()), 32'd2);
    chk("b2b_in_ready_low", 32'(low5), 32'd4);
    out_ready5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_reset_hold();
    test_back_to_back();
    chk("scoreboard8_empty", 32'(exp8_q.size()), 32'd0);
    chk("scoreboard5_empty", 32'(exp5_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
